// File: rtl/sd_access_arbiter.sv
// Two-client arbiter in front of sd_controller: grants whole sector transactions,
// issues sd_wr/sd_rd for the owner, routes byte strobes and data, and reports done/err.
module sd_access_arbiter #(
  parameter int BLOCK_BYTES   = 512,
  parameter int ISSUE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        c0_req,
  input  logic        c0_we,
  input  logic [31:0] c0_address,
  input  logic [7:0]  c0_din,
  output logic        c0_gnt,
  output logic        c0_next_byte,
  output logic [7:0]  c0_dout,
  output logic        c0_byte_available,
  output logic        c0_done,
  output logic        c0_err,
  input  logic        c1_req,
  input  logic        c1_we,
  input  logic [31:0] c1_address,
  input  logic [7:0]  c1_din,
  output logic        c1_gnt,
  output logic        c1_next_byte,
  output logic [7:0]  c1_dout,
  output logic        c1_byte_available,
  output logic        c1_done,
  output logic        c1_err,
  input  logic        sd_ready,
  input  logic        sd_ready_for_next_byte,
  input  logic        sd_byte_available,
  input  logic [7:0]  sd_dout,
  output logic        sd_wr,
  output logic        sd_rd,
  output logic [31:0] sd_address,
  output logic [7:0]  sd_din,
  output logic [1:0]  fsm_state
);

  localparam int TW = $clog2(ISSUE_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST    = TW'(ISSUE_TIMEOUT - 1);
  localparam logic [9:0]    BB       = 10'(BLOCK_BYTES);
  localparam logic [9:0]    CNT_MAX  = 10'h3FF;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2, DONE = 2'd3} state_t;

  state_t        state_q, state_d;
  logic          owner, prio, we_l, err_l, gnt_l, strb_prev;
  logic [9:0]    byte_cnt;
  logic [TW-1:0] timer;
  logic          pick, grant, timeout, strobe, done_now, err_now;

  // Handshake: a client holds req (with we/address) level-high until its done
  // pulse; the transaction is accepted on the edge where gnt is registered.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    timeout = 1'b0;
    pick    = (c0_req && c1_req) ? prio : c1_req;
    case (state_q)
      IDLE:  if (sd_ready && (c0_req || c1_req)) begin
               grant   = 1'b1;
               state_d = ISSUE;
             end
      ISSUE: if (!sd_ready) begin
               state_d = BUSY;
             end else if (timer == TLAST) begin
               timeout = 1'b1;
               state_d = DONE;
             end
      BUSY:  if (sd_ready) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= 1'b0;
      prio       <= 1'b0;
      we_l       <= 1'b0;
      err_l      <= 1'b0;
      gnt_l      <= 1'b0;
      strb_prev  <= 1'b0;
      byte_cnt   <= '0;
      timer      <= '0;
      sd_wr      <= 1'b0;
      sd_rd      <= 1'b0;
      sd_address <= '0;
    end else begin
      strb_prev <= strobe;
      if (grant) begin
        owner      <= pick;
        gnt_l      <= 1'b1;
        sd_address <= pick ? c1_address : c0_address;
        we_l       <= pick ? c1_we : c0_we;
        sd_wr      <= pick ? c1_we : c0_we;
        sd_rd      <= pick ? !c1_we : !c0_we;
        byte_cnt   <= '0;
        timer      <= '0;
      end
      if (state_q == ISSUE) begin
        timer <= timer + TW'(1);
        if (state_d != ISSUE) begin
          sd_wr <= 1'b0;
          sd_rd <= 1'b0;
        end
        if (timeout) err_l <= 1'b1;
      end
      // Count rising edges only; the controller may hold a strobe for several cycles.
      if (state_q == BUSY && strobe && !strb_prev && byte_cnt != CNT_MAX)
        byte_cnt <= byte_cnt + 10'd1;
      if (state_q == DONE) begin
        gnt_l <= 1'b0;
        prio  <= ~owner;
        err_l <= 1'b0;
      end
    end
  end

  assign strobe   = we_l ? sd_ready_for_next_byte : sd_byte_available;
  assign done_now = (state_q == DONE);
  assign err_now  = err_l | (byte_cnt != BB);

  assign c0_gnt            = gnt_l & ~owner;
  assign c1_gnt            = gnt_l & owner;
  assign c0_next_byte      = sd_ready_for_next_byte & c0_gnt;
  assign c1_next_byte      = sd_ready_for_next_byte & c1_gnt;
  assign c0_byte_available = sd_byte_available & c0_gnt;
  assign c1_byte_available = sd_byte_available & c1_gnt;
  assign c0_dout           = c0_gnt ? sd_dout : 8'h00;
  assign c1_dout           = c1_gnt ? sd_dout : 8'h00;
  assign c0_done           = done_now & ~owner;
  assign c1_done           = done_now & owner;
  assign c0_err            = done_now & ~owner & err_now;
  assign c1_err            = done_now & owner & err_now;
  assign sd_din            = c0_gnt ? c0_din : (c1_gnt ? c1_din : 8'h00);
  assign fsm_state         = state_q;

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Directed bench for sd_access_arbiter: the bench plays sd_controller and both
// clients; completions are checked against a queue of expected {client, err}.
module tb_sd_access_arbiter;

  logic        clk;
  logic        reset_n;
  logic        c0_req, c0_we, c1_req, c1_we;
  logic [31:0] c0_address, c1_address;
  logic [7:0]  c0_din, c1_din;
  logic        c0_gnt, c0_next_byte, c0_byte_available, c0_done, c0_err;
  logic        c1_gnt, c1_next_byte, c1_byte_available, c1_done, c1_err;
  logic [7:0]  c0_dout, c1_dout;
  logic        sd_ready, sd_ready_for_next_byte, sd_byte_available;
  logic [7:0]  sd_dout;
  logic        sd_wr, sd_rd;
  logic [31:0] sd_address;
  logic [7:0]  sd_din;
  logic [1:0]  fsm_state;

  logic [1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int nb0, nb1, ba0, ba1;

  sd_access_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .c0_req(c0_req), .c0_we(c0_we), .c0_address(c0_address), .c0_din(c0_din),
    .c0_gnt(c0_gnt), .c0_next_byte(c0_next_byte), .c0_dout(c0_dout),
    .c0_byte_available(c0_byte_available), .c0_done(c0_done), .c0_err(c0_err),
    .c1_req(c1_req), .c1_we(c1_we), .c1_address(c1_address), .c1_din(c1_din),
    .c1_gnt(c1_gnt), .c1_next_byte(c1_next_byte), .c1_dout(c1_dout),
    .c1_byte_available(c1_byte_available), .c1_done(c1_done), .c1_err(c1_err),
    .sd_ready(sd_ready), .sd_ready_for_next_byte(sd_ready_for_next_byte),
    .sd_byte_available(sd_byte_available), .sd_dout(sd_dout),
    .sd_wr(sd_wr), .sd_rd(sd_rd), .sd_address(sd_address), .sd_din(sd_din),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, {20'h0, c0_gnt, c1_gnt, c0_done, c1_done, c0_err, c1_err,
        c0_next_byte, c1_next_byte, c0_byte_available, c1_byte_available, sd_wr, sd_rd}, 32'h0);
    chk({tag, "_addr"}, sd_address, 32'h0);
    chk({tag, "_data"}, {8'h0, c0_dout, c1_dout, sd_din}, 32'h0);
    chk({tag, "_state"}, {30'h0, fsm_state}, 32'h0);
  endtask

  // scoreboard: strobe counters and completion checks, sampled mid-low-phase
  always @(negedge clk) begin
    logic [1:0] e;
    #2;
    if (reset_n) begin
      nb0 += int'(c0_next_byte);
      nb1 += int'(c1_next_byte);
      ba0 += int'(c0_byte_available);
      ba1 += int'(c1_byte_available);
      if (c0_done || c1_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("done_client", {31'h0, c1_done}, {31'h0, e[1]});
          chk("done_err", {31'h0, (c1_done ? c1_err : c0_err)}, {31'h0, e[0]});
        end
      end
    end
  end

  // driver: plays sd_controller for one granted transaction
  task automatic serve(input int cl, input logic [31:0] addr, input logic we,
                       input int nbytes, input int abort_at, input logic scramble);
    int  scnt;
    logic is_wr, own, seen;
    nb0 = 0; nb1 = 0; ba0 = 0; ba1 = 0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sd_wr || sd_rd) begin seen = 1'b1; break; end
      tick();
    end
    chk("strobe_wait", {31'h0, seen}, 32'h1);
    if (!seen) return;
    is_wr = sd_wr;
    own   = c1_gnt;
    chk("owner", {30'h0, c1_gnt, c0_gnt}, (cl == 1) ? 32'h2 : 32'h1);
    chk("sd_address", sd_address, addr);
    chk("strobe_kind", {30'h0, sd_wr, sd_rd}, {30'h0, we, ~we});
    if (scramble) begin
      c0_address = $urandom; c0_we = ~c0_we;
      c1_address = $urandom; c1_we = ~c1_we;
    end
    scnt = 1;
    repeat (3) begin tick(); scnt += int'(sd_wr | sd_rd); end
    sd_ready = 1'b0;
    tick(); scnt += int'(sd_wr | sd_rd);
    chk("strobe_len", scnt, 4);
    for (int b = 0; b < nbytes; b++) begin
      if (b == abort_at) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        return;
      end
      c0_din = 8'($urandom_range(0, 255));
      c1_din = 8'($urandom_range(0, 255));
      if (is_wr) sd_ready_for_next_byte = 1'b1;
      else begin sd_byte_available = 1'b1; sd_dout = 8'(b); end
      #1;
      if (b == 0 || b == nbytes - 1) begin
        if (is_wr) chk("sd_din", {24'h0, sd_din}, {24'h0, (cl == 1) ? c1_din : c0_din});
        else       chk("dout", {24'h0, (cl == 1) ? c1_dout : c0_dout}, 32'(b & 255));
      end
      tick();
      sd_ready_for_next_byte = 1'b0;
      sd_byte_available = 1'b0;
      tick();
    end
    if (scramble) chk("addr_hold", sd_address, addr);
    sd_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (c0_done || c1_done) begin seen = 1'b1; break; end
    end
    chk("done_wait", {31'h0, seen}, 32'h1);
    chk("byte_pulses", own ? (is_wr ? nb1 : ba1) : (is_wr ? nb0 : ba0), nbytes);
    chk("nonowner_strobes", own ? (nb0 + ba0) : (nb1 + ba1), 0);
    tick();
    chk("gnt_release", {31'h0, c0_gnt | c1_gnt}, 32'h0);
  endtask

  initial begin
    int  cnt;
    logic seen;
    reset_n = 1'b0;
    c0_req = 0; c0_we = 0; c0_address = 0; c0_din = 0;
    c1_req = 0; c1_we = 0; c1_address = 0; c1_din = 0;
    sd_ready = 1'b1; sd_ready_for_next_byte = 0; sd_byte_available = 0; sd_dout = 0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick();
    chk("idle_no_gnt", {31'h0, c0_gnt | c1_gnt}, 32'h0);

    // single write from c0
    c0_we = 1'b1; c0_address = 32'h400; c0_req = 1'b1;
    exp_q.push_back(2'b00);
    tick();
    chk("grant_latency", {30'h0, c0_gnt, sd_wr}, 32'h3);
    serve(0, 32'h400, 1'b1, 512, -1, 1'b1);
    c0_req = 1'b0;

    // contention after reset: c0, then alternating c1, c0, c1
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    c0_we = 1'b1; c0_address = 32'h1000; c1_we = 1'b0; c1_address = 32'h2000;
    c0_req = 1'b1; c1_req = 1'b1;
    exp_q.push_back(2'b00); exp_q.push_back(2'b10);
    exp_q.push_back(2'b00); exp_q.push_back(2'b10);
    serve(0, 32'h1000, 1'b1, 512, -1, 1'b0);
    serve(1, 32'h2000, 1'b0, 512, -1, 1'b0);
    serve(0, 32'h1000, 1'b1, 512, -1, 1'b0);
    serve(1, 32'h2000, 1'b0, 512, -1, 1'b0);
    c0_req = 1'b0; c1_req = 1'b0;

    // read routing to c1
    c1_we = 1'b0; c1_address = 32'h800; c1_req = 1'b1;
    exp_q.push_back(2'b10);
    serve(1, 32'h800, 1'b0, 512, -1, 1'b0);
    c1_req = 1'b0;

    // short transfer
    c0_we = 1'b1; c0_address = 32'hC00; c0_req = 1'b1;
    exp_q.push_back(2'b01);
    serve(0, 32'hC00, 1'b1, 300, -1, 1'b0);
    c0_req = 1'b0;

    // issue timeout: sd_ready never falls
    c1_we = 1'b0; c1_address = 32'h1200; c1_req = 1'b1;
    exp_q.push_back(2'b11);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (c1_gnt) begin seen = 1'b1; break; end
    end
    chk("timeout_grant", {31'h0, seen}, 32'h1);
    chk("timeout_strobe", {31'h0, sd_rd}, 32'h1);
    cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      cnt++;
      if (c1_done) break;
    end
    chk("timeout_cycles", cnt, 1024);
    chk("timeout_strobe_drop", {31'h0, sd_rd}, 32'h0);
    c1_req = 1'b0;
    tick();

    // reset in the middle of a read
    c1_address = 32'h1400; c1_req = 1'b1;
    exp_q.push_back(2'b10);
    serve(1, 32'h1400, 1'b0, 512, 100, 1'b0);
    exp_q.delete();
    sd_ready_for_next_byte = 1'b0; sd_byte_available = 1'b0; sd_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    c0_we = 1'b1; c0_address = 32'h1800; c0_req = 1'b1;
    repeat (3) tick();
    chk("no_gnt_without_ready", {31'h0, c0_gnt | c1_gnt}, 32'h0);
    sd_ready = 1'b1;
    exp_q.push_back(2'b00);
    serve(0, 32'h1800, 1'b1, 512, -1, 1'b0);
    c0_req = 1'b0; c1_req = 1'b0;
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
